// File: rtl/pio_pkg.sv
// Shared PIO constants, OSR state encoding and the 5-bit count decoder,
// where a field value of 0 stands for 32.
package pio_pkg;

  localparam int PIO_W = 32;
  localparam int CNT_W = 6;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_FIFO = 1'b1
  } osr_state_e;

  function automatic logic [CNT_W-1:0] decode_count(input logic [4:0] v);
    return (v == 5'd0) ? CNT_W'(PIO_W) : {1'b0, v};
  endfunction

endpackage

// File: rtl/osr_shift_dp.sv
// OSR datapath: extracts the OUT field (right-justified) and computes the
// register value after the field has been shifted out, for either direction.
module osr_shift_dp
  import pio_pkg::*;
(
  input  logic [PIO_W-1:0] data,
  input  logic             dir,
  input  logic [CNT_W-1:0] shift_val,
  output logic [PIO_W-1:0] dout,
  output logic [PIO_W-1:0] shifted
);

  logic [CNT_W-1:0] rem;
  logic [PIO_W-1:0] mask;

  // rem is 0 for a full-width OUT, so the mask becomes all ones
  assign rem  = CNT_W'(PIO_W) - shift_val;
  assign mask = {PIO_W{1'b1}} >> rem;

  always_comb begin
    if (dir) begin
      dout    = data & mask;
      shifted = data >> shift_val;
    end else begin
      dout    = data >> rem;
      shifted = data << shift_val;
    end
  end

endmodule

// File: rtl/osr.sv
// PIO output shift register: FIFO/MOV loading, OUT shifting, shift counter,
// pull-threshold compare and execute-stage stall generation.
//
// state     | meaning
// RUN       | normal operation, no blocked request outstanding
// WAIT_FIFO | OUT (autopull) or blocking PULL stalled on an empty TX FIFO
module osr
  import pio_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             penable,
  input  logic             stalled,
  input  logic             out_req,
  input  logic             pull_req,
  input  logic             pull_block,
  input  logic             pull_ifempty,
  input  logic             mov_set,
  input  logic [PIO_W-1:0] mov_din,
  input  logic [4:0]       shift,
  input  logic             dir,
  input  logic             autopull,
  input  logic [4:0]       pull_thresh,
  input  logic             fifo_empty,
  input  logic [PIO_W-1:0] fifo_din,
  output logic             fifo_pop,
  output logic [PIO_W-1:0] dout,
  output logic             stall_out,
  output logic [PIO_W-1:0] osr_value,
  output logic [CNT_W-1:0] shift_count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIO_W);

  osr_state_e       state, state_nxt;
  logic [PIO_W-1:0] shift_reg, shift_reg_nxt, shifted;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] shift_val, thresh_val;
  logic [CNT_W:0]   count_sum;
  logic             en, at_thresh;

  assign en         = penable && !stalled;
  assign shift_val  = decode_count(shift);
  assign thresh_val = decode_count(pull_thresh);
  assign at_thresh  = (count >= thresh_val);
  assign count_sum  = {1'b0, count} + {1'b0, shift_val};

  osr_shift_dp u_dp (
    .data      (shift_reg),
    .dir       (dir),
    .shift_val (shift_val),
    .dout      (dout),
    .shifted   (shifted)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      shift_reg <= '0;
      count     <= CNT_FULL;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_reg_nxt;
      count     <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        RUN:       if (stall_out && fifo_empty) state_nxt = WAIT_FIFO;
        WAIT_FIFO: if (!fifo_empty || !(out_req || pull_req)) state_nxt = RUN;
        default:   state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    shift_reg_nxt = shift_reg;
    count_nxt     = count;
    fifo_pop      = 1'b0;
    stall_out     = 1'b0;
    if (en) begin
      if (mov_set) begin
        shift_reg_nxt = mov_din;
        count_nxt     = '0;
      end else if (pull_req) begin
        // below threshold, ifempty or autopull turns PULL into a no-op
        if ((pull_ifempty || autopull) && !at_thresh) begin
          shift_reg_nxt = shift_reg;
        end else if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_reg_nxt = fifo_din;
          count_nxt     = '0;
        end else if (pull_block) begin
          stall_out = 1'b1;
        end else begin
          shift_reg_nxt = mov_din;
          count_nxt     = '0;
        end
      end else if (out_req) begin
        if (autopull && at_thresh) begin
          stall_out = 1'b1;
          if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            shift_reg_nxt = fifo_din;
            count_nxt     = '0;
          end
        end else begin
          shift_reg_nxt = shifted;
          count_nxt     = (count_sum > {1'b0, CNT_FULL}) ? CNT_FULL : count_sum[CNT_W-1:0];
        end
      end else if (autopull && at_thresh && !fifo_empty) begin
        fifo_pop      = 1'b1;
        shift_reg_nxt = fifo_din;
        count_nxt     = '0;
      end
    end
  end

  assign osr_value   = shift_reg;
  assign shift_count = count;

endmodule

// File: tb/tb_osr.sv
// Directed bench for osr: hand-computed vectors for load, OUT, autopull,
// PULL variants, background refill and reset.
module tb_osr;
  import pio_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             penable, stalled, out_req, pull_req, pull_block, pull_ifempty, mov_set;
  logic [PIO_W-1:0] mov_din, fifo_din;
  logic [4:0]       shift, pull_thresh;
  logic             dir, autopull, fifo_empty;
  logic             fifo_pop, stall_out;
  logic [PIO_W-1:0] dout, osr_value;
  logic [CNT_W-1:0] shift_count;

  int checks = 0;
  int errors = 0;

  osr dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .penable      (penable),
    .stalled      (stalled),
    .out_req      (out_req),
    .pull_req     (pull_req),
    .pull_block   (pull_block),
    .pull_ifempty (pull_ifempty),
    .mov_set      (mov_set),
    .mov_din      (mov_din),
    .shift        (shift),
    .dir          (dir),
    .autopull     (autopull),
    .pull_thresh  (pull_thresh),
    .fifo_empty   (fifo_empty),
    .fifo_din     (fifo_din),
    .fifo_pop     (fifo_pop),
    .dout         (dout),
    .stall_out    (stall_out),
    .osr_value    (osr_value),
    .shift_count  (shift_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_out(input logic d, input logic [4:0] s);
    out_req = 1'b1; dir = d; shift = s;
  endtask

  initial begin
    reset_n = 1'b0; penable = 1'b1; stalled = 1'b0;
    out_req = 1'b0; pull_req = 1'b0; pull_block = 1'b0; pull_ifempty = 1'b0;
    mov_set = 1'b0; mov_din = '0; fifo_din = '0; shift = 5'd0; pull_thresh = 5'd0;
    dir = 1'b1; autopull = 1'b0; fifo_empty = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_osr",   osr_value, 32'h0);
    chk("rst_cnt",   32'(shift_count), 32'd32);
    chk("rst_pop",   32'(fifo_pop), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_dout",  dout, 32'h0);
    reset_n = 1'b1;
    tick();

    // blocking PULL with data available
    fifo_empty = 1'b0; fifo_din = 32'hDEADBEEF; pull_req = 1'b1; pull_block = 1'b1;
    settle();
    chk("pull_pop",   32'(fifo_pop), 32'd1);
    chk("pull_stall", 32'(stall_out), 32'd0);
    tick();
    chk("pull_osr", osr_value, 32'hDEADBEEF);
    chk("pull_cnt", 32'(shift_count), 32'd0);
    pull_req = 1'b0;
    settle();
    chk("idle_nopop", 32'(fifo_pop), 32'd0);

    // OUT right 8
    do_out(1'b1, 5'd8);
    settle();
    chk("outr_dout", dout, 32'h000000EF);
    tick();
    chk("outr_osr", osr_value, 32'h00DEADBE);
    chk("outr_cnt", 32'(shift_count), 32'd8);
    out_req = 1'b0;

    // MOV then OUT left 4, then full-width OUT left
    mov_set = 1'b1; mov_din = 32'hA0000005;
    tick();
    mov_set = 1'b0;
    chk("mov_cnt", 32'(shift_count), 32'd0);
    do_out(1'b0, 5'd4);
    settle();
    chk("outl_dout", dout, 32'h0000000A);
    tick();
    chk("outl_osr", osr_value, 32'h00000050);
    chk("outl_cnt", 32'(shift_count), 32'd4);
    do_out(1'b0, 5'd0);
    settle();
    chk("out32_dout", dout, 32'h00000050);
    tick();
    chk("out32_cnt", 32'(shift_count), 32'd32);
    chk("out32_osr", osr_value, 32'h0);
    out_req = 1'b0;

    // autopull stall on empty FIFO, then pop and re-issued OUT
    fifo_empty = 1'b1;
    mov_set = 1'b1; mov_din = 32'hCAFEF00D;
    tick();
    mov_set = 1'b0;
    do_out(1'b1, 5'd8);
    tick();
    chk("ap_pre_cnt", 32'(shift_count), 32'd8);
    autopull = 1'b1; pull_thresh = 5'd8;
    settle();
    chk("ap_stall", 32'(stall_out), 32'd1);
    chk("ap_nopop", 32'(fifo_pop), 32'd0);
    tick();
    tick();
    chk("ap_hold_osr", osr_value, 32'h00CAFEF0);
    chk("ap_hold_cnt", 32'(shift_count), 32'd8);
    fifo_empty = 1'b0; fifo_din = 32'h12345678;
    settle();
    chk("ap_pop",   32'(fifo_pop), 32'd1);
    chk("ap_stall2", 32'(stall_out), 32'd1);
    tick();
    chk("ap_osr", osr_value, 32'h12345678);
    chk("ap_cnt", 32'(shift_count), 32'd0);
    settle();
    chk("ap_reissue_stall", 32'(stall_out), 32'd0);
    chk("ap_reissue_dout",  dout, 32'h00000078);
    fifo_empty = 1'b1;
    tick();
    chk("ap_after_cnt", 32'(shift_count), 32'd8);
    chk("ap_after_osr", osr_value, 32'h00123456);
    out_req = 1'b0;

    // non-blocking PULL on empty FIFO, then ifempty below threshold
    autopull = 1'b0; pull_req = 1'b1; pull_block = 1'b0; mov_din = 32'h55;
    settle();
    chk("nbp_pop",   32'(fifo_pop), 32'd0);
    chk("nbp_stall", 32'(stall_out), 32'd0);
    tick();
    chk("nbp_osr", osr_value, 32'h55);
    chk("nbp_cnt", 32'(shift_count), 32'd0);
    pull_ifempty = 1'b1; mov_din = 32'h99;
    tick();
    chk("ife_osr", osr_value, 32'h55);
    chk("ife_cnt", 32'(shift_count), 32'd0);
    pull_req = 1'b0; pull_ifempty = 1'b0;

    // background refill at threshold 32
    autopull = 1'b1; pull_thresh = 5'd0;
    for (int i = 0; i < 4; i++) begin
      do_out(1'b1, 5'd8);
      settle();
      chk("bg_out_stall", 32'(stall_out), 32'd0);
      tick();
    end
    out_req = 1'b0;
    chk("bg_cnt32", 32'(shift_count), 32'd32);
    stalled = 1'b1; fifo_empty = 1'b0; fifo_din = 32'hBEEF0001;
    settle();
    chk("bg_stalled_pop", 32'(fifo_pop), 32'd0);
    tick();
    chk("bg_stalled_cnt", 32'(shift_count), 32'd32);
    stalled = 1'b0;
    settle();
    chk("bg_pop",   32'(fifo_pop), 32'd1);
    chk("bg_stall", 32'(stall_out), 32'd0);
    tick();
    chk("bg_osr", osr_value, 32'hBEEF0001);
    chk("bg_cnt", 32'(shift_count), 32'd0);
    settle();
    chk("bg_single_pop", 32'(fifo_pop), 32'd0);

    // blocking PULL on empty FIFO, penable gating, async reset mid-stall
    autopull = 1'b0; fifo_empty = 1'b1; pull_req = 1'b1; pull_block = 1'b1;
    settle();
    chk("bp_stall", 32'(stall_out), 32'd1);
    tick();
    chk("bp_hold", osr_value, 32'hBEEF0001);
    penable = 1'b0;
    settle();
    chk("bp_noen_stall", 32'(stall_out), 32'd0);
    penable = 1'b1;
    reset_n = 1'b0; pull_req = 1'b0;
    #1;
    chk("arst_osr",   osr_value, 32'h0);
    chk("arst_cnt",   32'(shift_count), 32'd32);
    chk("arst_stall", 32'(stall_out), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_cnt", 32'(shift_count), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
